// File: rtl/galaxian_dl_sequencer.sv
// ROM download sequencer for the Galaxian core: decodes data_io bytes into
// region write strobes, validates the image length and owns the core reset.
module galaxian_dl_sequencer #(
  parameter logic [15:0] IMAGE_SIZE  = 16'h6020,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        core_reset,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        pgm_we,
  output logic        rom1k_we,
  output logic        rom1h_we,
  output logic        prom_we,
  output logic        rom_loaded,
  output logic        load_error
);

  // state | meaning
  // IDLE  | no image yet, core held in reset
  // LOAD  | accepting ioctl bytes, core held in reset
  // HOLD  | settle countdown before releasing the core
  // RUN   | core running
  // FAIL  | last download invalid, core held until next valid download

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [16:0] CNT_FULL  = {1'b0, IMAGE_SIZE};
  localparam logic [16:0] CNT_MAX   = '1;
  localparam logic [15:0] PGM_END   = 16'h4000;
  localparam logic [15:0] ROM1K_END = 16'h5000;
  localparam logic [15:0] ROM1H_END = 16'h6000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic        downl_q, downl_d;
  logic [16:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  we_q, we_d;
  logic        loaded_q, loaded_d;
  logic        load_error_q, load_error_d;

  logic        dl_start;
  logic        dl_end;
  logic        byte_wr;
  logic        addr_in_range;
  logic [3:0]  region;

  // Region decode: bit0 PGM, bit1 1K, bit2 1H, bit3 6L PROM.
  always_comb begin
    dl_start      = ioctl_downl && !downl_q && (ioctl_index == ROM_INDEX);
    dl_end        = !ioctl_downl && downl_q;
    byte_wr       = (state_q == ST_LOAD) && ioctl_wr;
    addr_in_range = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < IMAGE_SIZE);
    region        = 4'b0000;
    if (addr_in_range) begin
      if (ioctl_addr[15:0] < PGM_END) begin
        region = 4'b0001;
      end else if (ioctl_addr[15:0] < ROM1K_END) begin
        region = 4'b0010;
      end else if (ioctl_addr[15:0] < ROM1H_END) begin
        region = 4'b0100;
      end else begin
        region = 4'b1000;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    downl_d      = ioctl_downl;
    cnt_d        = cnt_q;
    err_d        = err_q;
    hold_d       = hold_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 4'b0000;
    loaded_d     = loaded_q;
    load_error_d = load_error_q;

    case (state_q)
      ST_LOAD: begin
        if (byte_wr) begin
          addr_d = ioctl_addr[15:0];
          data_d = ioctl_dout;
          if (addr_in_range) begin
            we_d = region;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 17'd1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        // The verdict uses the updated count/error so a final byte that
        // coincides with the falling edge is included.
        if (dl_end) begin
          if ((cnt_d == CNT_FULL) && !err_d) begin
            state_d = ST_HOLD;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d      = ST_FAIL;
            load_error_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (user_reset) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == 16'd0) begin
          state_d  = ST_RUN;
          loaded_d = 1'b1;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      ST_RUN: begin
        if (user_reset) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      default: begin
      end
    endcase

    // A valid download start wins from any state.
    if (dl_start) begin
      state_d      = ST_LOAD;
      cnt_d        = 17'd0;
      err_d        = 1'b0;
      loaded_d     = 1'b0;
      load_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      downl_q      <= 1'b0;
      cnt_q        <= 17'd0;
      err_q        <= 1'b0;
      hold_q       <= 16'd0;
      addr_q       <= 16'd0;
      data_q       <= 8'd0;
      we_q         <= 4'b0000;
      loaded_q     <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      downl_q      <= downl_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      hold_q       <= hold_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      loaded_q     <= loaded_d;
      load_error_q <= load_error_d;
    end
  end

  assign core_reset = (state_q != ST_RUN);
  assign dl_addr    = addr_q;
  assign dl_data    = data_q;
  assign pgm_we     = we_q[0];
  assign rom1k_we   = we_q[1];
  assign rom1h_we   = we_q[2];
  assign prom_we    = we_q[3];
  assign rom_loaded = loaded_q;
  assign load_error = load_error_q;

endmodule
